// File: rtl/gate_truth_table_scanner_if.sv
// Bundle between the board controller / gate under test and the truth-table scanner.
// slave is the scanner side; master is the environment (controller plus gate).
interface gate_truth_table_scanner_if #(
    parameter int N_INPUTS = 2
);
    localparam int TBL_W = 1 << N_INPUTS;

    logic                start;
    logic                busy;
    logic                done;
    logic [N_INPUTS-1:0] gate_in;
    logic                gate_out;
    logic [TBL_W-1:0]    truth_table;
    logic                table_valid;

    modport slave (
        input  start, gate_out,
        output busy, done, gate_in, truth_table, table_valid
    );

    modport master (
        output start, gate_out,
        input  busy, done, gate_in, truth_table, table_valid
    );
endinterface

// File: rtl/gate_truth_table_scanner.sv
// Steps a combinational gate through every input vector, holds each for SETTLE_CYCLES+1
// cycles, and publishes the sampled outputs as one truth-table word.
module gate_truth_table_scanner #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    gate_truth_table_scanner_if.slave    bus
);
    localparam int TBL_W = 1 << N_INPUTS;
    localparam int SW    = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]       SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]       SETTLE_ONE = SW'(1);
    localparam logic [N_INPUTS-1:0] IDX_ONE    = N_INPUTS'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_e;

    state_e              state_q, state_d;
    logic [N_INPUTS-1:0] idx_q, idx_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic [TBL_W-1:0]    shadow_q, shadow_d;
    logic [N_INPUTS-1:0] gate_in_q, gate_in_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [TBL_W-1:0]    truth_table_q, truth_table_d;
    logic                table_valid_q, table_valid_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        settle_cnt_d  = settle_cnt_q;
        shadow_d      = shadow_q;
        gate_in_d     = gate_in_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        truth_table_d = truth_table_q;
        table_valid_d = table_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = DRIVE;
                    busy_d       = 1'b1;
                    gate_in_d    = '0;
                    idx_d        = '0;
                    settle_cnt_d = '0;
                end
            end
            DRIVE: begin
                if (settle_cnt_q == SETTLE_MAX) begin
                    settle_cnt_d     = '0;
                    shadow_d[idx_q]  = bus.gate_out;
                    if (&idx_q) begin
                        // Publish the full shadow, including the bit captured this cycle,
                        // in one step so a partial scan is never visible.
                        state_d       = DONE;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        gate_in_d     = '0;
                        idx_d         = '0;
                        truth_table_d = shadow_d;
                        table_valid_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + IDX_ONE;
                        gate_in_d = idx_q + IDX_ONE;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                gate_in_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            settle_cnt_q  <= '0;
            shadow_q      <= '0;
            gate_in_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            truth_table_q <= '0;
            table_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            settle_cnt_q  <= settle_cnt_d;
            shadow_q      <= shadow_d;
            gate_in_q     <= gate_in_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            truth_table_q <= truth_table_d;
            table_valid_q <= table_valid_d;
        end
    end

    assign bus.gate_in     = gate_in_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.truth_table = truth_table_q;
    assign bus.table_valid = table_valid_q;
endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// Directed bench: three scanner instances (AND/OR, XOR, majority) with a done-triggered scoreboard.
module tb_gate_truth_table_scanner;
    logic clk = 1'b0;
    logic rst_n;
    logic sel_or;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t0;

    typedef struct {
        logic [7:0] tbl;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_truth_table_scanner_if #(.N_INPUTS(2)) ifa ();
    gate_truth_table_scanner_if #(.N_INPUTS(2)) ifb ();
    gate_truth_table_scanner_if #(.N_INPUTS(3)) ifc ();

    assign ifa.gate_out = sel_or ? (ifa.gate_in[0] | ifa.gate_in[1]) : (ifa.gate_in[0] & ifa.gate_in[1]);
    assign ifb.gate_out = ifb.gate_in[0] ^ ifb.gate_in[1];
    assign ifc.gate_out = (ifc.gate_in[0] & ifc.gate_in[1]) | (ifc.gate_in[0] & ifc.gate_in[2]) |
                          (ifc.gate_in[1] & ifc.gate_in[2]);

    gate_truth_table_scanner #(.N_INPUTS(2), .SETTLE_CYCLES(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    gate_truth_table_scanner #(.N_INPUTS(2), .SETTLE_CYCLES(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    gate_truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: every done pulse pops one expected scan result.
    always @(negedge clk) begin
        exp_t e;
        if (ifa.done) begin
            if (qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_table", 32'(ifa.truth_table), 32'(e.tbl));
                chk("a_done_cycle", 32'(cyc), 32'(e.cyc));
                chk("a_valid", 32'(ifa.table_valid), 32'd1);
                chk("a_busy_at_done", 32'(ifa.busy), 32'd0);
            end
        end
        if (ifb.done) begin
            if (qb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_table", 32'(ifb.truth_table), 32'(e.tbl));
                chk("b_done_cycle", 32'(cyc), 32'(e.cyc));
                chk("b_valid", 32'(ifb.table_valid), 32'd1);
            end
        end
        if (ifc.done) begin
            if (qc.size() == 0) chk("c_unexpected_done", 32'd1, 32'd0);
            else begin
                e = qc.pop_front();
                chk("c_table", 32'(ifc.truth_table), 32'(e.tbl));
                chk("c_done_cycle", 32'(cyc), 32'(e.cyc));
                chk("c_valid", 32'(ifc.table_valid), 32'd1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        sel_or = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_busy", 32'(ifa.busy), 32'd0);
        chk("rst_a_done", 32'(ifa.done), 32'd0);
        chk("rst_a_gate_in", 32'(ifa.gate_in), 32'd0);
        chk("rst_a_table", 32'(ifa.truth_table), 32'd0);
        chk("rst_a_valid", 32'(ifa.table_valid), 32'd0);
        chk("rst_c_table", 32'(ifc.truth_table), 32'd0);
        rst_n = 1'b1;

        // AND scan, SETTLE=2: each vector held 3 cycles, done at t0+13
        @(negedge clk);
        ifa.start = 1'b1; t0 = cyc;
        qa.push_back(exp_t'{8'h08, t0 + 13});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            chk("a_busy", 32'(ifa.busy), 32'd1);
            chk("a_gate_in", 32'(ifa.gate_in), 32'((k - 1) / 3));
        end
        @(negedge clk);
        chk("a_gate_in_done", 32'(ifa.gate_in), 32'd0);
        repeat (3) @(negedge clk);

        // OR swapped in: old table held throughout, starts during scan and DONE ignored
        sel_or = 1'b1;
        @(negedge clk);
        ifa.start = 1'b1; t0 = cyc;
        qa.push_back(exp_t'{8'h0E, t0 + 13});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ifa.start = (k == 5) || (k == 12);
            chk("a_hold_table", 32'(ifa.truth_table), 32'h8);
            chk("a_hold_valid", 32'(ifa.table_valid), 32'd1);
        end
        @(negedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        chk("a_idle_after_done_start", 32'(ifa.busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("a_table_kept", 32'(ifa.truth_table), 32'hE);

        // Reset in cycle 6 of a scan clears everything asynchronously
        sel_or = 1'b0;
        @(negedge clk);
        ifa.start = 1'b1; t0 = cyc;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ifa.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(ifa.busy), 32'd0);
        chk("arst_done", 32'(ifa.done), 32'd0);
        chk("arst_gate_in", 32'(ifa.gate_in), 32'd0);
        chk("arst_table", 32'(ifa.truth_table), 32'd0);
        chk("arst_valid", 32'(ifa.table_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ifa.start = 1'b1; t0 = cyc;
        qa.push_back(exp_t'{8'h08, t0 + 13});
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            ifa.start = 1'b0;
        end

        // XOR scan, SETTLE=0: 4 busy cycles, done at t0+5
        @(negedge clk);
        ifb.start = 1'b1; t0 = cyc;
        qb.push_back(exp_t'{8'h06, t0 + 5});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            chk("b_busy", 32'(ifb.busy), 32'd1);
            chk("b_gate_in", 32'(ifb.gate_in), 32'(k - 1));
        end
        repeat (4) @(negedge clk);

        // start held for 40 cycles: done every 6 cycles, busy low for 2 between scans
        @(negedge clk);
        ifb.start = 1'b1; t0 = cyc;
        for (int j = 0; j <= 6; j++) qb.push_back(exp_t'{8'h06, t0 + 5 + 6 * j});
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 40) ifb.start = 1'b0;
            chk("b_held_busy", 32'(ifb.busy), (((k - 1) % 6) < 4) ? 32'd1 : 32'd0);
        end
        repeat (4) @(negedge clk);

        // 3-input majority, SETTLE=1: done at t0+17
        @(negedge clk);
        ifc.start = 1'b1; t0 = cyc;
        qc.push_back(exp_t'{8'hE8, t0 + 17});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ifc.start = 1'b0;
        end

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        chk("c_queue_drained", 32'(qc.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_truth_table_scanner.md
Name: gate_truth_table_scanner

Overview:
- Drives the inputs of a combinational gate under test (AND, OR, XOR, etc.) and reads back its output, stepping through every input combination.
- Assembles the sampled outputs into a truth-table word.
- Used on-board to characterise gate modules. Sits between the board controller (start/done) and the gate instance (gate_in/gate_out).

Parameters:
- N_INPUTS, 2, number of gate inputs driven. Legal range 1..4. Table width is 2^N_INPUTS.
- SETTLE_CYCLES, 2, cycles each vector is held before sampling. 0 is legal and means sample in the same cycle the vector is driven.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a scan; sampled only in IDLE
- gate_in  output  N_INPUTS  vector driven to the gate under test; bit 0 = input "a", bit 1 = input "b", ...
- gate_out  input  1  gate under test output
- busy  output  1  high while a scan is in progress
- done  output  1  single-cycle pulse when a scan completes
- truth_table  output  2^N_INPUTS  bit k = gate_out sampled while gate_in == k
- table_valid  output  1  truth_table holds a completed scan

Behaviour:
- Reset (async assert, sync release): state=IDLE, gate_in=0, busy=0, done=0, truth_table=0, table_valid=0, all counters 0.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 -> DRIVE next cycle, with idx=0 and settle_cnt=0.
  - start=0 -> stay in IDLE.
- DRIVE:
  - busy=1 and gate_in=idx (registered).
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES, gate_out is written into shadow[idx] and settle_cnt returns to 0.
    - If idx is not the last index: idx increments.
    - If idx == 2^N_INPUTS-1: next state is DONE.
  - Each vector is therefore held SETTLE_CYCLES+1 cycles.
  - Scan length: 2^N_INPUTS*(SETTLE_CYCLES+1) busy cycles.
- DONE (exactly one cycle):
  - done=1, busy=0, gate_in=0, table_valid=1.
  - truth_table shows the complete shadow in this same cycle. The shadow-to-output copy is registered on entry to DONE, so the table updates atomically and never shows a partial scan.
  - Next state: IDLE.
- Timing: with start high in cycle t, busy rises in t+1 and done pulses in cycle t+1+2^N*(SETTLE_CYCLES+1).
- gate_in is 0 whenever busy=0.
- start while busy, or during the DONE cycle, is ignored; no queuing.
- start held high continuously: a new scan begins the cycle after each DONE (back-to-back scans with one idle cycle).
- truth_table and table_valid keep their previous values through a new scan until the next DONE.
- Reset mid-scan: scan aborts immediately, all outputs return to reset values, and the previous table is lost.
- Counter widths:
  - idx is N_INPUTS bits wide; no wrap occurs because the scan stops at the last index.
  - settle_cnt is max(1, clog2(SETTLE_CYCLES+1)) bits.
- gate_out is treated as synchronous to clk; no synchroniser is included.

Test Plan:
- N=2, SETTLE=2, 2-input AND attached, start pulsed in cycle 0:
  - gate_in = 00,01,10,11, each held 3 cycles over cycles 1..12.
  - busy high cycles 1..12; done=1 in cycle 13.
  - truth_table=4'b1000, table_valid=1.
- N=2, SETTLE=0, XOR attached:
  - busy for 4 cycles; done in cycle 5.
  - truth_table=4'b0110.
- N=3, SETTLE=1, 3-input majority gate:
  - truth_table=8'b11101000; done at cycle 17.
- AND scan completes, then start again with an OR gate swapped in:
  - truth_table stays 4'b1000 throughout the second scan.
  - Becomes 4'b1110 exactly at the second done.
  - start pulses issued mid-scan have no effect.
- rst_n driven low during cycle 6 of a scan:
  - busy, done, gate_in, truth_table and table_valid are all 0 immediately (asynchronously).
  - A fresh start after release gives a normal full scan.
- start held high for 40 cycles, N=2, SETTLE=0:
  - done pulses every 6 cycles.
  - busy is low for exactly 2 cycles (DONE, IDLE) between scans.
